// File: rtl/axi_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite downstream path between NUM_MASTERS
// upstream masters. One transaction in flight; the grant is held until its response completes.

module axi_lite_arbiter_lane #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  gnt,
  input  logic                  ph_rd_addr,
  input  logic                  ph_rd_data,
  input  logic                  ph_wr_addr,
  input  logic                  ph_wr_resp,
  input  logic                  aw_done,
  input  logic                  w_done,
  input  logic                  s_arready,
  input  logic                  s_rvalid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_awready,
  input  logic                  s_wready,
  input  logic                  s_bvalid,
  input  logic [1:0]            s_bresp,
  output logic                  m_arready,
  output logic                  m_rvalid,
  output logic [DATA_WIDTH-1:0] m_rdata,
  output logic [1:0]            m_rresp,
  output logic                  m_awready,
  output logic                  m_wready,
  output logic                  m_bvalid,
  output logic [1:0]            m_bresp
);
  logic rd_sel, wr_sel;

  assign rd_sel    = gnt & ph_rd_data;
  assign wr_sel    = gnt & ph_wr_resp;

  // A channel that already completed its handshake must not see ready again.
  assign m_arready = gnt & ph_rd_addr & s_arready;
  assign m_awready = gnt & ph_wr_addr & ~aw_done & s_awready;
  assign m_wready  = gnt & ph_wr_addr & ~w_done & s_wready;

  assign m_rvalid  = rd_sel & s_rvalid;
  assign m_rdata   = rd_sel ? s_rdata : '0;
  assign m_rresp   = rd_sel ? s_rresp : '0;
  assign m_bvalid  = wr_sel & s_bvalid;
  assign m_bresp   = wr_sel ? s_bresp : '0;
endmodule

module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                                    clk,
  input  logic                                    reset,
  // upstream masters, index = requester id
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_araddr,
  input  logic [NUM_MASTERS-1:0]                   m_arvalid,
  output logic [NUM_MASTERS-1:0]                   m_arready,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_rdata,
  output logic [NUM_MASTERS-1:0][1:0]              m_rresp,
  output logic [NUM_MASTERS-1:0]                   m_rvalid,
  input  logic [NUM_MASTERS-1:0]                   m_rready,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]   m_awaddr,
  input  logic [NUM_MASTERS-1:0]                   m_awvalid,
  output logic [NUM_MASTERS-1:0]                   m_awready,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]   m_wdata,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0] m_wmask,
  input  logic [NUM_MASTERS-1:0]                   m_wvalid,
  output logic [NUM_MASTERS-1:0]                   m_wready,
  output logic [NUM_MASTERS-1:0][1:0]              m_bresp,
  output logic [NUM_MASTERS-1:0]                   m_bvalid,
  input  logic [NUM_MASTERS-1:0]                   m_bready,
  // downstream path to the crossbar
  output logic [ADDR_WIDTH-1:0]                    s_araddr,
  output logic                                     s_arvalid,
  input  logic                                     s_arready,
  input  logic [DATA_WIDTH-1:0]                    s_rdata,
  input  logic [1:0]                               s_rresp,
  input  logic                                     s_rvalid,
  output logic                                     s_rready,
  output logic [ADDR_WIDTH-1:0]                    s_awaddr,
  output logic                                     s_awvalid,
  input  logic                                     s_awready,
  output logic [DATA_WIDTH-1:0]                    s_wdata,
  output logic [DATA_WIDTH/8-1:0]                  s_wmask,
  output logic                                     s_wvalid,
  input  logic                                     s_wready,
  input  logic [1:0]                               s_bresp,
  input  logic                                     s_bvalid,
  output logic                                     s_bready
);
  localparam int PW = $clog2(NUM_MASTERS);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_t;

  state_t               state;
  logic [PW-1:0]        grant, rr_ptr;
  logic                 aw_done, w_done;
  logic [NUM_MASTERS-1:0] req;
  logic [PW-1:0]        win, win_nxt;
  logic                 win_found;
  logic                 ph_rd_addr, ph_rd_data, ph_wr_addr, ph_wr_resp;
  logic                 ar_fire, r_fire, aw_fire, w_fire, b_fire;

  assign req = m_arvalid | m_awvalid;

  // Rotating priority search starting at rr_ptr, wrap done by subtraction.
  always_comb begin
    logic [PW:0] idx;
    idx       = '0;
    win       = '0;
    win_found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_MASTERS)) idx = idx - (PW+1)'(NUM_MASTERS);
      if (!win_found && req[idx[PW-1:0]]) begin
        win_found = 1'b1;
        win       = idx[PW-1:0];
      end
    end
  end

  assign win_nxt    = (win == PW'(NUM_MASTERS-1)) ? '0 : win + 1'b1;

  assign ph_rd_addr = (state == RD_ADDR);
  assign ph_rd_data = (state == RD_DATA);
  assign ph_wr_addr = (state == WR_ADDR);
  assign ph_wr_resp = (state == WR_RESP);

  // Granted master is steered straight through; valids are gated by phase.
  assign s_araddr  = m_araddr[grant];
  assign s_arvalid = ph_rd_addr & m_arvalid[grant];
  assign s_rready  = ph_rd_data & m_rready[grant];
  assign s_awaddr  = m_awaddr[grant];
  assign s_awvalid = ph_wr_addr & ~aw_done & m_awvalid[grant];
  assign s_wdata   = m_wdata[grant];
  assign s_wmask   = m_wmask[grant];
  assign s_wvalid  = ph_wr_addr & ~w_done & m_wvalid[grant];
  assign s_bready  = ph_wr_resp & m_bready[grant];

  assign ar_fire = s_arvalid & s_arready;
  assign r_fire  = s_rvalid & s_rready;
  assign aw_fire = s_awvalid & s_awready;
  assign w_fire  = s_wvalid & s_wready;
  assign b_fire  = s_bvalid & s_bready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      grant   <= '0;
      rr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (win_found) begin
          grant  <= win;
          rr_ptr <= win_nxt;
          state  <= m_awvalid[win] ? WR_ADDR : RD_ADDR;
        end
        RD_ADDR: if (ar_fire) state <= RD_DATA;
        RD_DATA: if (r_fire)  state <= IDLE;
        WR_ADDR: begin
          if ((aw_done | aw_fire) && (w_done | w_fire)) begin
            state   <= WR_RESP;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            if (aw_fire) aw_done <= 1'b1;
            if (w_fire)  w_done  <= 1'b1;
          end
        end
        WR_RESP: if (b_fire) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_lane
    axi_lite_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .gnt        (grant == PW'(i)),
      .ph_rd_addr (ph_rd_addr),
      .ph_rd_data (ph_rd_data),
      .ph_wr_addr (ph_wr_addr),
      .ph_wr_resp (ph_wr_resp),
      .aw_done    (aw_done),
      .w_done     (w_done),
      .s_arready  (s_arready),
      .s_rvalid   (s_rvalid),
      .s_rdata    (s_rdata),
      .s_rresp    (s_rresp),
      .s_awready  (s_awready),
      .s_wready   (s_wready),
      .s_bvalid   (s_bvalid),
      .s_bresp    (s_bresp),
      .m_arready  (m_arready[i]),
      .m_rvalid   (m_rvalid[i]),
      .m_rdata    (m_rdata[i]),
      .m_rresp    (m_rresp[i]),
      .m_awready  (m_awready[i]),
      .m_wready   (m_wready[i]),
      .m_bvalid   (m_bvalid[i]),
      .m_bresp    (m_bresp[i])
    );
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Scoreboard bench for axi_lite_arbiter: per-master drivers, a small slave model,
// and a negedge monitor that pops expected responses on every upstream handshake.
module tb_axi_lite_arbiter;
  localparam int N = 2, AW = 32, DW = 32, MW = DW/8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0] m_araddr, m_awaddr;
  logic [N-1:0][DW-1:0] m_rdata, m_wdata;
  logic [N-1:0][MW-1:0] m_wmask;
  logic [N-1:0][1:0]    m_rresp, m_bresp;
  logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
  logic [N-1:0] m_wvalid, m_wready, m_bvalid, m_bready;
  logic [AW-1:0] s_araddr, s_awaddr;
  logic [DW-1:0] s_rdata, s_wdata;
  logic [MW-1:0] s_wmask;
  logic [1:0]    s_rresp, s_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
  logic s_wvalid, s_wready, s_bvalid, s_bready;

  axi_lite_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wmask(m_wmask), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wmask(s_wmask), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    int          lead;
  } cmd_t;

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   act;
  logic [1:0] rr_block = 2'b00;

  assign m_rready = ~rr_block;
  assign m_bready = '1;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // ---------------- upstream master drivers ----------------
  for (genvar g = 0; g < N; g++) begin : drv
    cmd_t q[$];
    logic        arv = 1'b0, awv = 1'b0, wv = 1'b0;
    logic [31:0] adr = '0, wd = '0;
    logic [3:0]  wm = '0;
    bit          busy = 1'b0;

    assign m_arvalid[g] = arv;
    assign m_awvalid[g] = awv;
    assign m_wvalid[g]  = wv;
    assign m_araddr[g]  = adr;
    assign m_awaddr[g]  = adr;
    assign m_wdata[g]   = wd;
    assign m_wmask[g]   = wm;

    initial begin
      cmd_t c;
      bit   fa, fw, fd;
      int   lead, t;
      forever begin
        @(posedge clk); #1;
        if (q.size() == 0) continue;
        c = q.pop_front();
        busy = 1'b1;
        adr = c.addr; wd = c.data; wm = c.mask;
        lead = c.lead;
        arv = c.rd;
        wv  = c.wr;
        awv = c.wr && (lead == 0);
        t = 0;
        while ((arv || awv || wv || lead > 0) && t < 300) begin
          @(negedge clk);
          fa = arv & m_arready[g];
          fw = awv & m_awready[g];
          fd = wv & m_wready[g];
          @(posedge clk); #1;
          if (fa) arv = 1'b0;
          if (fw) awv = 1'b0;
          if (fd) wv = 1'b0;
          if (lead > 0) begin
            lead--;
            if (lead == 0) awv = 1'b1;
          end
          t++;
        end
        if (t >= 300) begin
          checks++; failures++;
          $display("FAIL drv%0d_handshake_timeout: got no handshake expected one within 300 cycles", g);
          arv = 1'b0; awv = 1'b0; wv = 1'b0;
        end
        busy = 1'b0;
      end
    end
  end

  // ---------------- downstream slave model ----------------
  int          aw_cnt = 0, w_cnt = 0;
  logic [31:0] last_awaddr = '0, last_wdata = '0;
  logic [3:0]  last_wmask = '0;

  initial begin
    bit          fa, fr, fw, fd, fb, got_aw, got_w;
    int          rd_cnt;
    logic [31:0] aa, rd_addr, wa, wdv;
    logic [3:0]  wmv;
    s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = '0;
    rd_cnt = 0; rd_addr = '0; got_aw = 1'b0; got_w = 1'b0;
    forever begin
      @(negedge clk);
      fa = s_arvalid & s_arready; fr = s_rvalid & s_rready;
      fw = s_awvalid & s_awready; fd = s_wvalid & s_wready; fb = s_bvalid & s_bready;
      aa = s_araddr; wa = s_awaddr; wdv = s_wdata; wmv = s_wmask;
      @(posedge clk); #1;
      if (!reset) begin
        s_arready = 1'b1; s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = '0;
        rd_cnt = 0; got_aw = 1'b0; got_w = 1'b0;
        continue;
      end
      if (fr) begin s_rvalid = 1'b0; s_arready = 1'b1; end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          s_rvalid = 1'b1;
          if (rd_addr == 32'h8000_0000)      begin s_rdata = 32'hDEAD_BEEF; s_rresp = 2'd0; end
          else if (rd_addr[31:28] == 4'hF)   begin s_rdata = '0;            s_rresp = 2'd3; end
          else                               begin s_rdata = ~rd_addr;      s_rresp = 2'd0; end
        end
      end
      if (fa) begin rd_addr = aa; s_arready = 1'b0; rd_cnt = 3; end
      if (fb) begin s_bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0; s_awready = 1'b1; s_wready = 1'b1; end
      if (fw) begin got_aw = 1'b1; s_awready = 1'b0; aw_cnt++; last_awaddr = wa; end
      if (fd) begin got_w = 1'b1; s_wready = 1'b0; w_cnt++; last_wdata = wdv; last_wmask = wmv; end
      if (got_aw && got_w && !s_bvalid) begin
        s_bvalid = 1'b1;
        s_bresp  = (last_awaddr[31:28] == 4'hF) ? 2'd3 : 2'd0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk_resp(input int id, input bit wr, input logic [31:0] data, input logic [1:0] resp);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_resp: got m%0d wr=%0d data=0x%0h resp=%0d expected no response", id, wr, data, resp);
    end else begin
      e = exp_q.pop_front();
      if (e.id != id || e.wr != wr || (!wr && e.data !== data) || e.resp !== resp) begin
        failures++;
        $display("FAIL resp_m%0d: got id=%0d wr=%0d data=0x%0h resp=%0d expected id=%0d wr=%0d data=0x%0h resp=%0d",
                 id, id, wr, data, resp, e.id, e.wr, e.data, e.resp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      act = 0;
      for (int g = 0; g < N; g++) begin
        if (m_rvalid[g] && m_rready[g]) chk_resp(g, 1'b0, m_rdata[g], m_rresp[g]);
        if (m_bvalid[g] && m_bready[g]) chk_resp(g, 1'b1, 32'h0, m_bresp[g]);
        if (m_arready[g] | m_rvalid[g] | m_awready[g] | m_wready[g] | m_bvalid[g]) act++;
      end
      if (act > 0) begin
        checks++;
        if (act > 1) begin
          failures++;
          $display("FAIL isolation: got %0d active masters expected 1", act);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_cmd(input int id, input cmd_t c);
    if (id == 0) drv[0].q.push_back(c);
    else         drv[1].q.push_back(c);
  endtask

  task automatic rd(input int id, input logic [31:0] a, input logic [31:0] d, input logic [1:0] r);
    cmd_t c; exp_t e;
    c.rd = 1'b1; c.wr = 1'b0; c.addr = a; c.data = '0; c.mask = '0; c.lead = 0;
    e.id = id; e.wr = 1'b0; e.data = d; e.resp = r;
    exp_q.push_back(e);
    push_cmd(id, c);
  endtask

  task automatic wr(input int id, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                    input int lead, input logic [1:0] r);
    cmd_t c; exp_t e;
    c.rd = 1'b0; c.wr = 1'b1; c.addr = a; c.data = d; c.mask = m; c.lead = lead;
    e.id = id; e.wr = 1'b1; e.data = '0; e.resp = r;
    exp_q.push_back(e);
    push_cmd(id, c);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || drv[0].q.size() != 0 || drv[1].q.size() != 0 ||
            drv[0].busy || drv[1].busy) && t < 1000) begin
      @(posedge clk); t++;
    end
    chk({name, "_drain_pending"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_s_rvalid(input string name);
    int t;
    t = 0;
    while (!s_rvalid && t < 50) begin @(negedge clk); t++; end
    chk({name, "_s_rvalid_seen"}, 64'(s_rvalid), 64'd1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int aw0, w0;
    cmd_t c;
    exp_t e;

    #2;
    chk("reset_outputs", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                              |m_arready, |m_rvalid, |m_awready, |m_wready, |m_bvalid,
                              |m_rdata, |m_rresp, |m_bresp}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // single read by m0
    rd(0, 32'h8000_0000, 32'hDEAD_BEEF, 2'd0);
    drain("single_read");

    // m1 alone (pointer returns to 0), then a simultaneous pair: m0 first
    rd(1, 32'h1000_0004, 32'hEFFF_FFFB, 2'd0);
    drain("m1_read");
    rd(0, 32'h2000_0000, 32'hDFFF_FFFF, 2'd0);
    rd(1, 32'h3000_0010, 32'hCFFF_FFEF, 2'd0);
    drain("pair_ptr0");

    // m0 alone with a DECERR (pointer -> 1), then a pair: m1 first
    rd(0, 32'hF000_0000, 32'h0000_0000, 2'd3);
    drain("decerr_read");
    rd(1, 32'h4000_0000, 32'hBFFF_FFFF, 2'd0);
    rd(0, 32'h5000_0000, 32'hAFFF_FFFF, 2'd0);
    drain("pair_ptr1");

    // both masters streaming: strict alternation starting at m1
    rd(1, 32'h0000_0100, 32'hFFFF_FEFF, 2'd0);
    rd(0, 32'h0000_0200, 32'hFFFF_FDFF, 2'd0);
    rd(1, 32'h0000_0400, 32'hFFFF_FBFF, 2'd0);
    rd(0, 32'h0000_0800, 32'hFFFF_F7FF, 2'd0);
    drain("alternate");

    // m1 write with W leading AW by 2 cycles
    aw0 = aw_cnt; w0 = w_cnt;
    wr(1, 32'hA000_03F8, 32'h1234_5678, 4'hF, 2, 2'd0);
    drain("write_w_first");
    chk("wfirst_aw_count", 64'(aw_cnt - aw0), 64'd1);
    chk("wfirst_w_count",  64'(w_cnt - w0),   64'd1);
    chk("wfirst_awaddr",   64'(last_awaddr),  64'hA000_03F8);
    chk("wfirst_wdata",    64'(last_wdata),   64'h1234_5678);
    chk("wfirst_wmask",    64'(last_wmask),   64'hF);

    // write to an unmapped region: DECERR passed through
    wr(0, 32'hF000_0040, 32'h0BAD_0BAD, 4'h1, 0, 2'd3);
    drain("write_decerr");

    // same master presents read and write together: write completes first
    aw0 = aw_cnt; w0 = w_cnt;
    c.rd = 1'b1; c.wr = 1'b1; c.addr = 32'h0000_0300; c.data = 32'hCAFE_F00D; c.mask = 4'h3; c.lead = 0;
    e.id = 0; e.wr = 1'b1; e.data = '0; e.resp = 2'd0;
    exp_q.push_back(e);
    e.id = 0; e.wr = 1'b0; e.data = 32'hFFFF_FCFF; e.resp = 2'd0;
    exp_q.push_back(e);
    push_cmd(0, c);
    drain("rd_wr_same");
    chk("rdwr_aw_count", 64'(aw_cnt - aw0), 64'd1);
    chk("rdwr_wdata",    64'(last_wdata),   64'hCAFE_F00D);
    chk("rdwr_wmask",    64'(last_wmask),   64'h3);

    // backpressure on m0 r channel holds the grant against m1
    rr_block[0] = 1'b1;
    rd(0, 32'h6000_0000, 32'h9FFF_FFFF, 2'd0);
    wait_s_rvalid("bp");
    rd(1, 32'h7000_0000, 32'h8FFF_FFFF, 2'd0);
    repeat (5) begin
      @(negedge clk);
      chk("bp_s_rready",    64'(s_rready),     64'd0);
      chk("bp_m0_rvalid",   64'(m_rvalid[0]),  64'd1);
      chk("bp_m1_arready",  64'(m_arready[1]), 64'd0);
      chk("bp_s_arvalid",   64'(s_arvalid),    64'd0);
    end
    @(posedge clk); #1;
    rr_block[0] = 1'b0;
    drain("backpressure");

    // asynchronous reset while in RD_DATA
    rr_block[0] = 1'b1;
    rd(0, 32'h8000_0000, 32'hDEAD_BEEF, 2'd0);
    wait_s_rvalid("rst");
    reset = 1'b0;
    #1;
    chk("midreset_outputs", 64'({s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready,
                                 |m_arready, |m_rvalid, |m_awready, |m_wready, |m_bvalid,
                                 |m_rdata, |m_rresp, |m_bresp}), 64'd0);
    exp_q.delete();
    rr_block[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    // pointer is back at 0, so m0 wins a simultaneous pair
    rd(0, 32'h8000_0000, 32'hDEAD_BEEF, 2'd0);
    rd(1, 32'h0000_1000, 32'hFFFF_EFFF, 2'd0);
    drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion expected finish before 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
